// File: rtl/matmul_result_uart_streamer_pkg.sv
// matmul_result_uart_streamer_pkg: shared FSM encoding, header default and byte-per-word helper
package matmul_result_uart_streamer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WAIT_HI, S_WAIT_LO, S_FETCH, S_LATCH, S_SEND, S_CSUM, S_DONE
  } state_e;
  typedef enum logic [1:0] {K_HDR, K_DATA, K_CSUM} kind_e;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  function automatic int bpw(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/matmul_result_uart_streamer.sv
// matmul_result_uart_streamer: streams the result buffer to uart_tx as header, MSB-first words, XOR checksum
module matmul_result_uart_streamer
  import matmul_result_uart_streamer_pkg::*;
#(
  parameter int          N_ELEMS  = 16,
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i
);
  localparam int BPW = bpw(DATA_W);
  localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;
  state_e              state_q, state_d;
  kind_e               kind_q, kind_d;
  logic [ADDR_W-1:0]   word_q, word_d, addr_q, addr_d;
  logic [BW-1:0]       byte_q, byte_d;
  logic [7:0]          csum_q, csum_d, tx_data_q, tx_data_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                abort_q, abort_d;
  logic                last_byte, last_word;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      kind_q    <= K_HDR;
      word_q    <= '0;
      addr_q    <= '0;
      byte_q    <= '0;
      csum_q    <= '0;
      tx_data_q <= '0;
      shreg_q   <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      csum_q    <= csum_d;
      tx_data_q <= tx_data_d;
      shreg_q   <= shreg_d;
      abort_q   <= abort_d;
    end
  end
  assign last_byte = byte_q == BW'(BPW - 1);
  assign last_word = word_q == ADDR_W'(N_ELEMS - 1);
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    word_d    = word_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    csum_d    = csum_q;
    tx_data_d = tx_data_q;
    shreg_d   = shreg_q;
    // abort is remembered so a short pulse during a frame still ends the packet at the frame boundary
    abort_d   = (state_q != S_IDLE) && (abort_q || abort_i);
    case (state_q)
      S_IDLE: if (start_i && !tx_busy_i && !abort_i) begin
        state_d   = S_HDR;
        kind_d    = K_HDR;
        csum_d    = '0;
        word_d    = '0;
        byte_d    = '0;
        tx_data_d = HDR_BYTE;
      end
      S_HDR, S_CSUM: state_d = abort_i ? S_IDLE : S_WAIT_HI;
      S_SEND: if (abort_i) state_d = S_IDLE;
      else begin
        state_d = S_WAIT_HI;
        csum_d  = csum_q ^ tx_data_q;
        shreg_d = shreg_q << 8;
      end
      S_WAIT_HI: state_d = tx_busy_i ? S_WAIT_LO : S_WAIT_HI;
      S_WAIT_LO: if (!tx_busy_i) begin
        if (abort_q || abort_i) state_d = S_IDLE;
        else if (kind_q == K_CSUM) state_d = S_DONE;
        else if (kind_q == K_DATA && !last_byte) begin
          state_d   = S_SEND;
          byte_d    = byte_q + BW'(1);
          tx_data_d = shreg_q[DATA_W-1 -: 8];
        end else if (kind_q == K_DATA && last_word) begin
          state_d   = S_CSUM;
          kind_d    = K_CSUM;
          tx_data_d = csum_q;
        end else begin
          state_d = S_FETCH;
          word_d  = kind_q == K_DATA ? word_q + ADDR_W'(1) : word_q;
        end
      end
      S_FETCH: begin
        addr_d  = word_q;
        state_d = abort_i ? S_IDLE : S_LATCH;
      end
      S_LATCH: if (abort_i) state_d = S_IDLE;
      else begin
        state_d   = S_SEND;
        kind_d    = K_DATA;
        byte_d    = '0;
        shreg_d   = mem_rd_data_i;
        tx_data_d = mem_rd_data_i[DATA_W-1 -: 8];
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    busy_o        = state_q != S_IDLE;
    done_o        = state_q == S_DONE;
    mem_rd_en_o   = state_q == S_FETCH;
    mem_rd_addr_o = state_q == S_FETCH ? word_q : addr_q;
    tx_start_o    = (state_q inside {S_HDR, S_SEND, S_CSUM}) && !abort_i;
    tx_data_o     = tx_data_q;
  end
endmodule

// File: tb/tb_matmul_result_uart_streamer.sv
// tb_matmul_result_uart_streamer: directed checks with behavioural uart_tx and result RAM models
module tb_matmul_result_uart_streamer;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic busy_a, done_a, rd_en_a, tx_start_a, tx_busy_a;
  logic busy_b, done_b, rd_en_b, tx_start_b, tx_busy_b;
  logic [0:0] addr_a;
  logic [3:0] addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [31:0] mem_a [2] = '{32'h11223344, 32'hAABBCCDD};
  logic [31:0] mem_b [16] = '{default: 32'h0};
  logic [7:0] exp_a [10] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
  int cnt_a, cnt_b;
  logic [7:0] log_a [$];
  logic [7:0] log_b [$];
  int dones_a = 0, dones_b = 0, viol_a = 0, viol_b = 0, unstable_a = 0;
  int passed = 0, total = 0;

  matmul_result_uart_streamer #(.N_ELEMS(2), .DATA_W(32), .ADDR_W(1), .HDR_BYTE(8'hA5)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a), .busy_o(busy_a),
    .done_o(done_a), .mem_rd_en_o(rd_en_a), .mem_rd_addr_o(addr_a), .mem_rd_data_i(rd_data_a),
    .tx_data_o(tx_data_a), .tx_start_o(tx_start_a), .tx_busy_i(tx_busy_a));
  matmul_result_uart_streamer #(.N_ELEMS(16), .DATA_W(32), .ADDR_W(4), .HDR_BYTE(8'hA5)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b), .busy_o(busy_b),
    .done_o(done_b), .mem_rd_en_o(rd_en_b), .mem_rd_addr_o(addr_b), .mem_rd_data_i(rd_data_b),
    .tx_data_o(tx_data_b), .tx_start_o(tx_start_b), .tx_busy_i(tx_busy_b));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_a <= 0;
    else if (tx_start_a) cnt_a <= 20;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_b <= 0;
    else if (tx_start_b) cnt_b <= 20;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  assign tx_busy_a = cnt_a != 0;
  assign tx_busy_b = cnt_b != 0;
  always_ff @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[addr_a];
  always_ff @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[addr_b];

  always @(negedge clk) begin
    if (tx_start_a) begin
      log_a.push_back(tx_data_a);
      if (tx_busy_a) viol_a++;
    end
    if (tx_busy_a && log_a.size() > 0 && tx_data_a !== log_a[$]) unstable_a++;
    if (done_a) dones_a++;
    if (tx_start_b) begin
      log_b.push_back(tx_data_b);
      if (tx_busy_b) viol_b++;
    end
    if (done_b) dones_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_a) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else passed++;
    total++; if (done_a !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_a); else passed++;
    total++; if (tx_start_a !== 1'b0) $display("FAIL reset_tx_start got=%b exp=0", tx_start_a); else passed++;
    total++; if (tx_data_a !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data_a); else passed++;
    total++; if (rd_en_a !== 1'b0 || addr_a !== 1'b0) $display("FAIL reset_mem got=%b/%h exp=0/0", rd_en_a, addr_a); else passed++;
    total++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b got=%b exp=0", busy_b); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_packet();
    int b0 = log_a.size(), d0 = dones_a;
    bit ok;
    pulse_start_a();
    total++; if (busy_a !== 1'b1) $display("FAIL pkt_busy_after_start got=%b exp=1", busy_a); else passed++;
    wait_done_a(1000, ok);
    total++; if (!ok) $display("FAIL pkt_done_timeout got=0 exp=1"); else passed++;
    tick();
    total++; if (busy_a !== 1'b0) $display("FAIL pkt_busy_after_done got=%b exp=0", busy_a); else passed++;
    total++; if (log_a.size() - b0 != 10) $display("FAIL pkt_len got=%0d exp=10", log_a.size() - b0); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (b0 + i >= log_a.size() || log_a[b0+i] !== exp_a[i]) $display("FAIL pkt_byte%0d got=%h exp=%h", i, log_a[b0+i], exp_a[i]);
      else passed++;
    end
    total++; if (dones_a - d0 != 1) $display("FAIL pkt_done_count got=%0d exp=1", dones_a - d0); else passed++;
    total++; if (viol_a != 0) $display("FAIL pkt_start_while_busy got=%0d exp=0", viol_a); else passed++;
  endtask

  task automatic test_all_zero();
    int b0 = log_b.size(), d0 = dones_b, low = 0, nz = 0;
    bit ok = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy_b) low++;
      if (done_b) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    total++; if (!ok) $display("FAIL zero_done_timeout got=0 exp=1"); else passed++;
    total++; if (log_b.size() - b0 != 66) $display("FAIL zero_len got=%0d exp=66", log_b.size() - b0); else passed++;
    total++; if (log_b[b0] !== 8'hA5) $display("FAIL zero_hdr got=%h exp=a5", log_b[b0]); else passed++;
    for (int i = b0 + 1; i < log_b.size(); i++) if (log_b[i] !== 8'h00) nz++;
    total++; if (nz != 0) $display("FAIL zero_payload_nonzero got=%0d exp=0", nz); else passed++;
    total++; if (low != 0) $display("FAIL zero_busy_low_cycles got=%0d exp=0", low); else passed++;
    total++; if (dones_b - d0 != 1) $display("FAIL zero_done_count got=%0d exp=1", dones_b - d0); else passed++;
    total++; if (viol_b != 0) $display("FAIL zero_start_while_busy got=%0d exp=0", viol_b); else passed++;
  endtask

  task automatic test_start_ignored();
    int b0 = log_a.size(), d0 = dones_a;
    bit ok;
    pulse_start_a();
    repeat (100) tick();
    pulse_start_a();
    wait_done_a(1000, ok);
    total++; if (!ok) $display("FAIL ign_done_timeout got=0 exp=1"); else passed++;
    repeat (60) tick();
    total++; if (busy_a !== 1'b0) $display("FAIL ign_busy got=%b exp=0", busy_a); else passed++;
    total++; if (log_a.size() - b0 != 10) $display("FAIL ign_len got=%0d exp=10", log_a.size() - b0); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (b0 + i >= log_a.size() || log_a[b0+i] !== exp_a[i]) $display("FAIL ign_byte%0d got=%h exp=%h", i, log_a[b0+i], exp_a[i]);
      else passed++;
    end
    total++; if (dones_a - d0 != 1) $display("FAIL ign_done_count got=%0d exp=1", dones_a - d0); else passed++;
  endtask

  task automatic test_abort();
    int b0 = log_a.size(), d0 = dones_a, waited = 0;
    bit seen = 1'b0, fell = 1'b0;
    logic busy_at_fall = 1'b1;
    pulse_start_a();
    for (int i = 0; i < 500 && !seen; i++) begin
      if (log_a.size() >= b0 + 3) seen = 1'b1;
      else tick();
    end
    total++; if (!seen) $display("FAIL abort_reach_0x22 got=%0d exp=3", log_a.size() - b0); else passed++;
    abort_a = 1'b1;
    for (int i = 0; i < 100 && !fell; i++) begin
      if (!busy_a) begin
        fell = 1'b1;
        busy_at_fall = tx_busy_a;
      end else begin
        tick();
        waited++;
      end
    end
    repeat (5) tick();
    abort_a = 1'b0;
    repeat (30) tick();
    total++; if (!fell) $display("FAIL abort_busy_timeout got=1 exp=0"); else passed++;
    total++; if (busy_at_fall !== 1'b0 || waited < 19) $display("FAIL abort_frame_truncated got=%b/%0d exp=0/>=19", busy_at_fall, waited); else passed++;
    total++; if (log_a.size() - b0 != 3) $display("FAIL abort_len got=%0d exp=3", log_a.size() - b0); else passed++;
    total++; if (log_a[$] !== 8'h22) $display("FAIL abort_last_byte got=%h exp=22", log_a[$]); else passed++;
    total++; if (dones_a - d0 != 0) $display("FAIL abort_done got=%0d exp=0", dones_a - d0); else passed++;
    b0 = log_a.size();
    abort_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    repeat (3) tick();
    total++; if (busy_a !== 1'b0 || log_a.size() != b0) $display("FAIL abort_start_same_cycle got=%b/%0d exp=0/0", busy_a, log_a.size() - b0); else passed++;
  endtask

  task automatic test_reset_mid();
    int b0 = log_a.size(), bm;
    bit seen = 1'b0, ok;
    pulse_start_a();
    for (int i = 0; i < 500 && !seen; i++) begin
      if (log_a.size() >= b0 + 6) seen = 1'b1;
      else tick();
    end
    total++; if (!seen) $display("FAIL rmid_reach_word1 got=%0d exp=6", log_a.size() - b0); else passed++;
    repeat (40) tick();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy_a, done_a, rd_en_a, tx_start_a, addr_a, tx_data_a} !== 13'h0)
      $display("FAIL rmid_outputs got=%b%b%b%b_%h_%h exp=0000_0_00", busy_a, done_a, rd_en_a, tx_start_a, addr_a, tx_data_a);
    else passed++;
    bm = log_a.size();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++; if (log_a.size() != bm) $display("FAIL rmid_start_in_reset got=%0d exp=0", log_a.size() - bm); else passed++;
    pulse_start_a();
    wait_done_a(1000, ok);
    tick();
    total++; if (!ok) $display("FAIL rmid_done_timeout got=0 exp=1"); else passed++;
    total++; if (log_a.size() - bm != 10) $display("FAIL rmid_len got=%0d exp=10", log_a.size() - bm); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bm + i >= log_a.size() || log_a[bm+i] !== exp_a[i]) $display("FAIL rmid_byte%0d got=%h exp=%h", i, log_a[bm+i], exp_a[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int b0 = log_a.size(), d0 = dones_a, u0 = unstable_a;
    bit ok;
    pulse_start_a();
    wait_done_a(1000, ok);
    total++; if (!ok) $display("FAIL b2b_done1_timeout got=0 exp=1"); else passed++;
    tick();
    pulse_start_a();
    total++; if (busy_a !== 1'b1) $display("FAIL b2b_restart got=%b exp=1", busy_a); else passed++;
    wait_done_a(1000, ok);
    tick();
    total++; if (!ok) $display("FAIL b2b_done2_timeout got=0 exp=1"); else passed++;
    total++; if (log_a.size() - b0 != 20) $display("FAIL b2b_len got=%0d exp=20", log_a.size() - b0); else passed++;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (b0 + i >= log_a.size() || log_a[b0+i] !== exp_a[i%10]) $display("FAIL b2b_byte%0d got=%h exp=%h", i, log_a[b0+i], exp_a[i%10]);
      else passed++;
    end
    total++; if (dones_a - d0 != 2) $display("FAIL b2b_done_count got=%0d exp=2", dones_a - d0); else passed++;
    total++; if (unstable_a != u0 || unstable_a != 0) $display("FAIL b2b_tx_data_stable got=%0d exp=0", unstable_a); else passed++;
    total++; if (viol_a != 0) $display("FAIL b2b_start_while_busy got=%0d exp=0", viol_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_packet();
    test_all_zero();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
